// File: rtl/fir_axilite_cfg_if.sv
// AXI-Lite configuration bus bundle for the FIR accelerator.
// Optional macro AXIL_RESP_EN adds the write response channel and rresp.
//
// Handshake rule for every channel: a transfer happens on the rising clock
// edge where both valid and ready are high; once valid is raised, the source
// holds valid and its payload stable until that edge.
interface fir_axilite_cfg_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;
`ifdef AXIL_RESP_EN
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;
  logic [1:0]             rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready, bready,
    input  awready, wready, arready, rvalid, rdata, bresp, bvalid, rresp
  );
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready, bready,
    output awready, wready, arready, rvalid, rdata, bresp, bvalid, rresp
  );
`else
  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
`endif
endinterface

// File: rtl/fir_axilite_cfg.sv
// AXI-Lite responder for the FIR configuration space: ap_ctrl (0x00),
// data_length (0x10) and the tap window (0x20..) mapped onto the tap BRAM.
// While a run is active the tap BRAM port belongs to the FIR core.
// Optional macro AXIL_RESP_EN adds bresp/bvalid/bready and rresp.
module fir_axilite_cfg #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  fir_axilite_cfg_if.slave       axil,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic [pADDR_WIDTH-1:0] core_tap_A,
  output logic                   ap_start_pulse,
  input  logic                   core_done,
  output logic [31:0]            data_length,
  output logic [1:0]             dbg_w_state,
  output logic [1:0]             dbg_r_state
);
  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
  localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32);
  localparam logic [pADDR_WIDTH-1:0] TAP_LAST  = pADDR_WIDTH'(32 + 4 * (Tape_Num - 1));

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_BRAM, R_DATA} r_state_t;

  w_state_t r_w_state, w_w_next;
  r_state_t r_r_state, w_r_next;

  logic [pADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [pDATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [31:0]            r_len;
  logic                   r_ap_start, r_ap_done, r_ap_idle, r_start_pulse;
  logic                   r_cap;
  logic                   w_tap_wr;

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= TAP_BASE) && (a <= TAP_LAST);
  endfunction

  // An idle-time AXI tap write owns the BRAM port during its ack cycle
  assign w_tap_wr = (r_w_state == W_ACK) && is_tap(r_awaddr) && r_ap_idle;

  // State registers for both channel FSMs
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_w_state <= W_IDLE;
      r_r_state <= R_IDLE;
    end else begin
      r_w_state <= w_w_next;
      r_r_state <= w_r_next;
    end
  end

  // Write FSM: accept only when address and data arrive together
  always_comb begin
    w_w_next = r_w_state;
    case (r_w_state)
      W_IDLE: if (axil.awvalid && axil.wvalid) w_w_next = W_ACK;
`ifdef AXIL_RESP_EN
      W_ACK:  w_w_next = W_RESP;
      W_RESP: if (axil.bready) w_w_next = W_IDLE;
`else
      W_ACK:  w_w_next = W_IDLE;
`endif
      default: w_w_next = W_IDLE;
    endcase
  end

  // Read FSM: tap reads take an extra BRAM cycle, deferred behind a tap write
  always_comb begin
    w_r_next = r_r_state;
    case (r_r_state)
      R_IDLE: if (axil.arvalid) w_r_next = R_ADDR;
      R_ADDR: w_r_next = is_tap(axil.araddr) ? R_BRAM : R_DATA;
      R_BRAM: if (!w_tap_wr) w_r_next = R_DATA;
      R_DATA: if (axil.rready) w_r_next = R_IDLE;
      default: w_r_next = R_IDLE;
    endcase
  end

  // Capture the write address and data as the pair is accepted
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_awaddr <= '0;
      r_wdata  <= '0;
    end else if (r_w_state == W_IDLE && axil.awvalid && axil.wvalid) begin
      r_awaddr <= axil.awaddr;
      r_wdata  <= axil.wdata;
    end
  end

  // Read data path: register values latched at R_ADDR, BRAM data captured once
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_araddr <= '0;
      r_rdata  <= '0;
      r_cap    <= 1'b0;
    end else begin
      case (r_r_state)
        R_ADDR: begin
          r_araddr <= axil.araddr;
          if (axil.araddr == ADDR_CTRL)
            r_rdata <= {{(pDATA_WIDTH-3){1'b0}}, r_ap_idle, r_ap_done, r_ap_start};
          else if (axil.araddr == ADDR_LEN)
            r_rdata <= pDATA_WIDTH'(r_len);
          else
            r_rdata <= '0;
        end
        R_BRAM: begin
          if (!r_ap_idle)
            r_rdata <= '1;
          else if (!w_tap_wr)
            r_cap <= 1'b1;
        end
        R_DATA: begin
          r_cap <= 1'b0;
          if (r_cap) r_rdata <= tap_Do;
        end
        default: r_cap <= 1'b0;
      endcase
    end
  end

  // ap_ctrl and data_length; core_done is applied last so it wins a clear
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_ap_start    <= 1'b0;
      r_ap_done     <= 1'b0;
      r_ap_idle     <= 1'b1;
      r_start_pulse <= 1'b0;
      r_len         <= '0;
    end else begin
      r_ap_start    <= 1'b0;
      r_start_pulse <= 1'b0;
      if (r_w_state == W_ACK && r_ap_idle) begin
        if (r_awaddr == ADDR_CTRL && r_wdata[0]) begin
          r_ap_start    <= 1'b1;
          r_start_pulse <= 1'b1;
          r_ap_idle     <= 1'b0;
        end
        if (r_awaddr == ADDR_LEN) r_len <= 32'(r_wdata);
      end
      if (r_r_state == R_DATA && axil.rready && r_araddr == ADDR_CTRL)
        r_ap_done <= 1'b0;
      if (core_done) begin
        r_ap_done <= 1'b1;
        r_ap_idle <= 1'b1;
      end
    end
  end

  // Tap BRAM port arbitration: core while busy, then AXI write, then AXI read
  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (!r_ap_idle) begin
      tap_EN = 1'b1;
      tap_A  = core_tap_A;
    end else if (w_tap_wr) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = r_awaddr - TAP_BASE;
      tap_Di = r_wdata;
    end else if (r_r_state == R_BRAM) begin
      tap_EN = 1'b1;
      tap_A  = r_araddr - TAP_BASE;
    end
  end

`ifdef AXIL_RESP_EN
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  logic [1:0] r_bresp, r_rresp;

  // Response codes: SLVERR for unmapped space or tap access while busy
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_bresp <= RESP_OKAY;
      r_rresp <= RESP_OKAY;
    end else begin
      if (r_w_state == W_ACK)
        r_bresp <= ((r_awaddr != ADDR_CTRL && r_awaddr != ADDR_LEN && !is_tap(r_awaddr)) ||
                    (is_tap(r_awaddr) && !r_ap_idle)) ? RESP_SLVERR : RESP_OKAY;
      if (r_r_state == R_ADDR)
        r_rresp <= ((axil.araddr != ADDR_CTRL && axil.araddr != ADDR_LEN && !is_tap(axil.araddr)) ||
                    (is_tap(axil.araddr) && !r_ap_idle)) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign axil.bvalid = (r_w_state == W_RESP);
  assign axil.bresp  = r_bresp;
  assign axil.rresp  = r_rresp;
`endif

  assign axil.awready   = (r_w_state == W_ACK);
  assign axil.wready    = (r_w_state == W_ACK);
  assign axil.arready   = (r_r_state == R_ADDR);
  assign axil.rvalid    = (r_r_state == R_DATA);
  assign axil.rdata     = r_cap ? tap_Do : r_rdata;
  assign ap_start_pulse = r_start_pulse;
  assign data_length    = r_len;
  assign dbg_w_state    = r_w_state;
  assign dbg_r_state    = r_r_state;
endmodule

// File: tb/tb_fir_axilite_cfg.sv
// Self-checking bench for fir_axilite_cfg with a behavioural register/tap
// model and a 1-cycle-latency tap BRAM.
module tb_fir_axilite_cfg;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NT = 11;

  // ---------------- clock / reset ----------------
  logic axis_clk = 1'b0;
  logic axis_rst = 1'b1;
  always #5 axis_clk = ~axis_clk;

  fir_axilite_cfg_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) axil ();
  logic [3:0]    tap_WE;
  logic          tap_EN;
  logic [DW-1:0] tap_Di, tap_Do;
  logic [AW-1:0] tap_A, core_tap_A;
  logic          ap_start_pulse, core_done;
  logic [31:0]   data_length;
  logic [1:0]    dbg_w_state, dbg_r_state;

  fir_axilite_cfg #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
    .axis_clk       (axis_clk),
    .axis_rst       (axis_rst),
    .axil           (axil),
    .tap_WE         (tap_WE),
    .tap_EN         (tap_EN),
    .tap_Di         (tap_Di),
    .tap_A          (tap_A),
    .tap_Do         (tap_Do),
    .core_tap_A     (core_tap_A),
    .ap_start_pulse (ap_start_pulse),
    .core_done      (core_done),
    .data_length    (data_length),
    .dbg_w_state    (dbg_w_state),
    .dbg_r_state    (dbg_r_state)
  );

  // Tap BRAM: read-first, one cycle read latency
  logic [DW-1:0] bram [0:15];
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) bram[tap_A[5:2]] <= tap_Di;
      tap_Do <= bram[tap_A[5:2]];
    end
  end

  int pulse_cnt = 0;
  always @(negedge axis_clk) if (ap_start_pulse) pulse_cnt <= pulse_cnt + 1;

  // ---------------- reference model ----------------
  logic [31:0] m_tap [NT];
  logic [31:0] m_len;
  logic        m_idle, m_done;
  logic [31:0] exp_q [$];

  function automatic logic is_tap_addr(input logic [11:0] a);
    return (a >= 12'd32) && (a <= 12'(32 + 4 * (NT - 1)));
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    if (a == 12'h000) return {29'd0, m_idle, m_done, 1'b0};
    if (a == 12'h010) return m_len;
    if (is_tap_addr(a)) return m_idle ? m_tap[(a - 12'd32) / 4] : 32'hFFFF_FFFF;
    return 32'd0;
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] d);
    if (m_idle) begin
      if (a == 12'h010) m_len = d;
      if (is_tap_addr(a)) m_tap[(a - 12'd32) / 4] = d;
      if (a == 12'h000 && d[0]) m_idle = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_len = 0; m_idle = 1'b1; m_done = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, output int ack_cyc);
    axil.awaddr = a; axil.wdata = d; axil.awvalid = 1'b1; axil.wvalid = 1'b1;
    ack_cyc = 0;
    do begin @(posedge axis_clk); #1; ack_cyc++; end
    while (!(axil.awready && axil.wready) && ack_cyc < 20);
    @(posedge axis_clk); #1;
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
`ifdef AXIL_RESP_EN
    for (int i = 0; i < 20 && !axil.bvalid; i++) begin @(posedge axis_clk); #1; end
    @(posedge axis_clk); #1;
`endif
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d);
    int cyc;
    axi_write(a, d, cyc);
    check($sformatf("wr_ack_%03h", a), 32'(cyc <= 2), 32'd1);
    model_write(a, d);
  endtask

  task automatic axi_read(input logic [11:0] a, input int hold, output logic [31:0] d, output int lat);
    logic [31:0] first;
    axil.araddr = a; axil.arvalid = 1'b1; lat = 0;
    do begin @(posedge axis_clk); #1; lat++; end
    while (!axil.arready && lat < 20);
    check("arready", 32'(axil.arready), 32'd1);
    @(posedge axis_clk); #1; lat++;
    axil.arvalid = 1'b0;
    while (!axil.rvalid && lat < 40) begin @(posedge axis_clk); #1; lat++; end
    check("rvalid", 32'(axil.rvalid), 32'd1);
    first = axil.rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge axis_clk); #1;
      check("rvalid_hold", 32'(axil.rvalid), 32'd1);
      check("rdata_hold", axil.rdata, first);
    end
    axil.rready = 1'b1;
    @(posedge axis_clk); #1;
    axil.rready = 1'b0;
    d = first;
  endtask

  task automatic do_read(input string tag, input logic [11:0] a, input int hold, input int extra_lat);
    logic [31:0] d;
    int lat;
    exp_q.push_back(model_read(a));
    axi_read(a, hold, d, lat);
    check({tag, "_data"}, d, exp_q.pop_front());
    check({tag, "_lat"}, 32'(lat), 32'((is_tap_addr(a) ? 3 : 2) + extra_lat));
    if (a == 12'h000) m_done = 1'b0;
  endtask

  task automatic pulse_core_done();
    core_done = 1'b1;
    @(posedge axis_clk); #1;
    core_done = 1'b0;
    m_done = 1'b1; m_idle = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [11:0] unmapped [8] = '{12'h004, 12'h008, 12'h00C, 12'h014, 12'h01C, 12'h04C, 12'h100, 12'hFFC};
  int coeff [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  initial begin
    int p0, seen;
    logic [11:0] a, b;
    logic [31:0] v;
    axil.awvalid = 0; axil.awaddr = 0; axil.wvalid = 0; axil.wdata = 0;
    axil.arvalid = 0; axil.araddr = 0; axil.rready = 0;
`ifdef AXIL_RESP_EN
    axil.bready = 1'b1;
`endif
    core_tap_A = 0; core_done = 0;
    for (int i = 0; i < 16; i++) bram[i] = 0;
    for (int i = 0; i < NT; i++) m_tap[i] = 0;
    model_reset();

    // Reset values
    repeat (3) @(posedge axis_clk);
    #1;
    check("rst_awready", 32'(axil.awready), 0);
    check("rst_wready", 32'(axil.wready), 0);
    check("rst_arready", 32'(axil.arready), 0);
    check("rst_rvalid", 32'(axil.rvalid), 0);
    check("rst_rdata", axil.rdata, 0);
    check("rst_tap_en_we", {27'd0, tap_EN, tap_WE}, 0);
    check("rst_pulse", 32'(ap_start_pulse), 0);
    check("rst_len", data_length, 0);
    axis_rst = 1'b0;
    @(posedge axis_clk); #1;

    do_read("ctrl_after_rst", 12'h000, 0, 0);
    do_read("len_after_rst", 12'h010, 0, 0);

    // Lone address or lone data is never acknowledged
    axil.awaddr = 12'h010; axil.awvalid = 1'b1; seen = 0;
    repeat (5) begin @(posedge axis_clk); #1; if (axil.awready || axil.wready) seen++; end
    axil.awvalid = 1'b0;
    check("lone_aw", 32'(seen), 0);
    axil.wdata = 32'h55; axil.wvalid = 1'b1; seen = 0;
    repeat (5) begin @(posedge axis_clk); #1; if (axil.awready || axil.wready) seen++; end
    axil.wvalid = 1'b0;
    check("lone_w", 32'(seen), 0);

    // Program length and taps
    do_write(12'h010, 32'd600);
    check("len_port", data_length, m_len);
    for (int i = 0; i < NT; i++) do_write(12'(32 + 4 * i), 32'(coeff[i]));
    do_read("tap_28", 12'h028, 0, 0);
    check("tap_28_value", m_tap[2], 32'hFFFF_FFF7);
    do_read("tap_30", 12'h030, 0, 0);

    // Randomized idle traffic
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: do_write(12'(32 + 4 * $urandom_range(0, NT - 1)), $urandom);
        1: do_write(12'h010, $urandom);
        2: do_write(unmapped[$urandom_range(0, 7)], $urandom);
        default: begin
          case ($urandom_range(0, 3))
            0: a = 12'h000;
            1: a = 12'h010;
            2: a = 12'(32 + 4 * $urandom_range(0, NT - 1));
            default: a = unmapped[$urandom_range(0, 7)];
          endcase
          do_read("rand_rd", a, 0, 0);
        end
      endcase
    end
    check("len_port_rand", data_length, m_len);

    // Read issued one cycle before a tap write: BRAM access defers
    a = 12'h024; b = 12'h040; v = $urandom;
    fork
      do_read("defer_rd", b, 0, 1);
      begin @(posedge axis_clk); #1; do_write(a, v); end
    join
    do_read("defer_wr_back", a, 0, 0);

    // Start a run
    p0 = pulse_cnt;
    do_write(12'h000, 32'd1);
    repeat (3) @(posedge axis_clk);
    #1;
    check("start_pulse_cnt", 32'(pulse_cnt - p0), 32'd1);
    do_read("ctrl_busy", 12'h000, 0, 0);
    p0 = pulse_cnt;
    do_write(12'h000, 32'd1);
    repeat (3) @(posedge axis_clk);
    #1;
    check("restart_ignored", 32'(pulse_cnt - p0), 32'd0);
    do_write(12'h010, $urandom);
    do_read("len_busy", 12'h010, 0, 0);
    do_write(12'h02C, $urandom);
    do_read("tap_busy", 12'h02C, 0, 0);
    for (int i = 0; i < 4; i++) begin
      core_tap_A = 12'(4 * $urandom_range(0, NT - 1));
      #1;
      check("core_tap_A", 32'(tap_A), 32'(core_tap_A));
      check("core_tap_en_we", {27'd0, tap_EN, tap_WE}, 32'h10);
      @(posedge axis_clk); #1;
    end

    // Completion: done seen once, then cleared by the read
    pulse_core_done();
    do_read("ctrl_done", 12'h000, 0, 0);
    do_read("ctrl_done_clr", 12'h000, 0, 0);
    do_read("tap_after_run", 12'h02C, 0, 0);

    // Back-pressure on a register read
    do_write(12'h010, $urandom);
    do_read("len_hold", 12'h010, 5, 0);

    // Reset while a tap read sits in its BRAM cycle
    do_write(12'h010, 32'd600);
    axil.araddr = 12'h030; axil.arvalid = 1'b1; seen = 0;
    while (!axil.arready && seen < 20) begin @(posedge axis_clk); #1; seen++; end
    @(posedge axis_clk); #1;
    axil.arvalid = 1'b0;
    axis_rst = 1'b1;
    #1;
    seen = 0;
    repeat (2) begin @(posedge axis_clk); #1; if (axil.rvalid) seen++; end
    axis_rst = 1'b0;
    model_reset();
    repeat (6) begin @(posedge axis_clk); #1; if (axil.rvalid) seen++; end
    check("rst_mid_read_rvalid", 32'(seen), 0);
    check("len_port_after_rst", data_length, m_len);
    do_read("len_after_mid_rst", 12'h010, 0, 0);
    do_read("ctrl_after_mid_rst", 12'h000, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
